// File: rtl/eth_header_parser_pkg.sv
// Shared Ethernet types, header geometry, ethertypes and parser state encoding.
// No logic; no latency; no backpressure.
package eth_pkg;

   typedef logic [47:0] mac_addr_t;
   typedef logic [15:0] eth_type_t;

   localparam int        ETH_HDR_BYTES = 14;
   localparam mac_addr_t MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;
   localparam eth_type_t ETH_TYPE_IPV4 = 16'h0800;
   localparam eth_type_t ETH_TYPE_ARP  = 16'h0806;

   typedef enum logic [1:0] {
      PS_HEADER  = 2'd0,
      PS_HDR_OUT = 2'd1,
      PS_PAYLOAD = 2'd2,
      PS_DROP    = 2'd3
   } parser_state_e;

   function automatic logic dest_accepted(input mac_addr_t dest, input mac_addr_t local_mac);
      return (dest == local_mac) || (dest == MAC_BROADCAST);
   endfunction

endpackage

// File: rtl/eth_header_parser_if.sv
// Parsed MAC header handoff: valid/ready handshake carrying dest/src MAC and ethertype.
// No latency; Transmitter holds valid and fields stable until ready.
interface ETH_HEADER_IF;
   import eth_pkg::*;

   logic      valid;
   logic      ready;
   mac_addr_t src_mac;
   mac_addr_t dest_mac;
   eth_type_t eth_type;

   modport Transmitter (output valid, src_mac, dest_mac, eth_type, input ready);
   modport Receiver    (input valid, src_mac, dest_mac, eth_type, output ready);

endinterface

// File: rtl/eth_header_parser.sv
// Extracts the 14-byte MAC header then passes payload through; dest filter under ETH_HEADER_PARSER_FILTER_EN.
// Latency: hdr valid 1 cycle after byte 13; payload is combinational pass-through.
// Backpressure: input stalls while the header waits for ready and follows m_axis_tready in payload.
module eth_header_parser
   import eth_pkg::*;
#(
   parameter mac_addr_t LOCAL_MAC = 48'h02_00_00_00_00_01
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   ETH_HEADER_IF.Transmitter       hdr,
   output logic [7:0]              m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    runt_err
);

   localparam logic [1:0] ST_HEADER  = PS_HEADER;
   localparam logic [1:0] ST_HDR_OUT = PS_HDR_OUT;
   localparam logic [1:0] ST_PAYLOAD = PS_PAYLOAD;
`ifdef ETH_HEADER_PARSER_FILTER_EN
   localparam logic [1:0] ST_DROP    = PS_DROP;
`endif

   logic [1:0]   r_state;
   logic [3:0]   r_cnt;
   logic [103:0] r_buf;
   logic         r_in_en;
   logic         r_runt;
   mac_addr_t    r_dest;
   mac_addr_t    r_src;
   eth_type_t    r_type;

   logic         w_s_acc;
   logic         w_hdr_done;
   logic         w_capture;

   assign w_s_acc    = s_axis_tvalid & s_axis_tready;
   assign w_hdr_done = (r_state == ST_HEADER) & w_s_acc & ~s_axis_tlast
                       & (r_cnt == 4'(ETH_HDR_BYTES - 1));
`ifdef ETH_HEADER_PARSER_FILTER_EN
   assign w_capture  = w_hdr_done & dest_accepted(r_buf[103:56], LOCAL_MAC);
`else
   assign w_capture  = w_hdr_done;
`endif

   always_comb begin
      s_axis_tready = 1'b0;
      case (r_state)
         ST_HEADER:  s_axis_tready = r_in_en;
         ST_PAYLOAD: s_axis_tready = m_axis_tready;
`ifdef ETH_HEADER_PARSER_FILTER_EN
         ST_DROP:    s_axis_tready = r_in_en;
`endif
         default:    s_axis_tready = 1'b0;
      endcase
   end

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tvalid = (r_state == ST_PAYLOAD) & s_axis_tvalid;
   assign m_axis_tlast  = (r_state == ST_PAYLOAD) & s_axis_tlast;
   assign hdr.valid     = (r_state == ST_HDR_OUT);
   assign hdr.dest_mac  = r_dest;
   assign hdr.src_mac   = r_src;
   assign hdr.eth_type  = r_type;
   assign runt_err      = r_runt;

   // Bytes 0..12 shift in so byte 0 ends up in the top octet; byte 13 is taken straight from the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HEADER;
         r_cnt   <= 4'd0;
         r_buf   <= '0;
         r_in_en <= 1'b0;
         r_runt  <= 1'b0;
      end else begin
         r_in_en <= 1'b1;
         r_runt  <= 1'b0;
         case (r_state)
            ST_HEADER: begin
               if (w_s_acc) begin
                  r_buf <= {r_buf[95:0], s_axis_tdata};
                  if (s_axis_tlast) begin
                     r_runt <= 1'b1;
                     r_cnt  <= 4'd0;
                  end else if (w_hdr_done) begin
                     r_cnt <= 4'd0;
`ifdef ETH_HEADER_PARSER_FILTER_EN
                     r_state <= w_capture ? ST_HDR_OUT : ST_DROP;
`else
                     r_state <= ST_HDR_OUT;
`endif
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            ST_HDR_OUT: begin
               if (hdr.ready) r_state <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               if (w_s_acc && s_axis_tlast) r_state <= ST_HEADER;
            end
`ifdef ETH_HEADER_PARSER_FILTER_EN
            ST_DROP: begin
               if (w_s_acc && s_axis_tlast) r_state <= ST_HEADER;
            end
`endif
            default: r_state <= ST_HEADER;
         endcase
      end
   end

   // Output fields change only when a header is accepted, so runts and dropped frames leave them intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dest <= '0;
         r_src  <= '0;
         r_type <= '0;
      end else if (w_capture) begin
         r_dest <= r_buf[103:56];
         r_src  <= r_buf[55:8];
         r_type <= {r_buf[7:0], s_axis_tdata};
      end
   end

endmodule

// File: tb/tb_eth_header_parser.sv
// Scoreboard bench: a frame-level model queues expected headers/payload/runts, a monitor checks DUT output.
module tb_eth_header_parser;
   import eth_pkg::*;

   localparam mac_addr_t LOCAL = 48'h02_00_00_00_00_01;
`ifdef ETH_HEADER_PARSER_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   typedef struct {
      mac_addr_t d;
      mac_addr_t s;
      eth_type_t t;
   } hdr_exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       s_axis_tlast = 1'b0;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       m_axis_tlast;
   logic       runt_err;

   ETH_HEADER_IF hif ();

   eth_header_parser #(.LOCAL_MAC(LOCAL)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .hdr           (hif),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .runt_err      (runt_err)
   );

   always #5 clk = ~clk;

   hdr_exp_t   hdr_q[$];
   logic [8:0] pay_q[$];
   logic [7:0] cur_fr[$];
   int         runt_exp = 0;
   int         runt_seen = 0;
   int         checks = 0;
   int         errors = 0;
   bit         rand_m = 1'b0;
   bit         rand_h = 1'b0;
   bit         hold_hdr = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic make_frame(input mac_addr_t d, input mac_addr_t s, input eth_type_t t,
                             input int npay, input bit rnd);
      cur_fr.delete();
      for (int i = 5; i >= 0; i--) cur_fr.push_back(d[8*i +: 8]);
      for (int i = 5; i >= 0; i--) cur_fr.push_back(s[8*i +: 8]);
      cur_fr.push_back(t[15:8]);
      cur_fr.push_back(t[7:0]);
      for (int i = 0; i < npay; i++)
         cur_fr.push_back(rnd ? 8'($urandom_range(255)) : 8'(i));
   endtask

   // Frame-level reference: short frames are runts, filtered frames vanish, others split at byte 14.
   task automatic expect_frame();
      hdr_exp_t e;
      int       n;
      n = cur_fr.size();
      if (n <= ETH_HDR_BYTES) begin
         runt_exp++;
         return;
      end
      e.d = '0;
      e.s = '0;
      for (int i = 0; i < 6; i++) e.d = {e.d[39:0], cur_fr[i]};
      for (int i = 6; i < 12; i++) e.s = {e.s[39:0], cur_fr[i]};
      e.t = {cur_fr[12], cur_fr[13]};
      if (FILTER && e.d != LOCAL && e.d != 48'hFFFF_FFFF_FFFF) return;
      hdr_q.push_back(e);
      for (int i = ETH_HDR_BYTES; i < n; i++) pay_q.push_back({i == n - 1, cur_fr[i]});
   endtask

   task automatic wait_accept();
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc) begin
         @(negedge clk);
         acc = s_axis_tready;
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 3000) begin
            checks++;
            errors++;
            $display("FAIL input_accept_timeout: tready still %0b after %0d cycles", s_axis_tready, n);
            return;
         end
      end
   endtask

   task automatic send_frame(input int gap_pct);
      for (int i = 0; i < cur_fr.size(); i++) begin
         if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = cur_fr[i];
         s_axis_tlast  = (i == cur_fr.size() - 1);
         wait_accept();
      end
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      m_axis_tready = 1'b1;
      hif.ready     = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rand_m ? 1'($urandom_range(1)) : 1'b1;
         hif.ready     = hold_hdr ? 1'b0 : (rand_h ? 1'($urandom_range(1)) : 1'b1);
      end
   end

   initial begin
      hdr_exp_t   e;
      logic [8:0] p;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hif.valid) begin
               check("m_tvalid_during_hdr", 64'(m_axis_tvalid), 64'd0);
               check("s_tready_during_hdr", 64'(s_axis_tready), 64'd0);
            end
            if (hif.valid && hif.ready) begin
               if (hdr_q.size() == 0) begin
                  check("unexpected_hdr", 64'(hif.dest_mac), 64'hDEAD_0000_0000_0000);
               end else begin
                  e = hdr_q.pop_front();
                  check("hdr_dest", 64'(hif.dest_mac), 64'(e.d));
                  check("hdr_src", 64'(hif.src_mac), 64'(e.s));
                  check("hdr_type", 64'(hif.eth_type), 64'(e.t));
                  check("hdr_before_payload", 64'(pay_q.size() > 0), 64'd1);
               end
            end
            if (m_axis_tvalid && m_axis_tready) begin
               if (pay_q.size() == 0) begin
                  check("unexpected_payload", 64'({m_axis_tlast, m_axis_tdata}), 64'h1_0000);
               end else begin
                  p = pay_q.pop_front();
                  check("payload", 64'({m_axis_tlast, m_axis_tdata}), 64'(p));
               end
            end
            if (runt_err) runt_seen++;
         end
      end
   end

   initial begin
      mac_addr_t d;

      @(negedge clk);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_hdr_valid", 64'(hif.valid), 64'd0);
      check("rst_hdr_dest", 64'(hif.dest_mac), 64'd0);
      check("rst_hdr_src", 64'(hif.src_mac), 64'd0);
      check("rst_hdr_type", 64'(hif.eth_type), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
      check("rst_runt", 64'(runt_err), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("tready_before_first_edge", 64'(s_axis_tready), 64'd0);
      @(negedge clk);
      check("tready_after_release", 64'(s_axis_tready), 64'd1);
      @(posedge clk);
      #1;

      // Broadcast ARP, incrementing payload, everything ready.
      make_frame(48'hFFFF_FFFF_FFFF, 48'h02_00_00_00_00_AA, ETH_TYPE_ARP, 28, 1'b0);
      expect_frame();
      send_frame(0);
      idle(5);

      // Same frame with the header handshake held off for 20 cycles.
      hold_hdr = 1'b1;
      make_frame(48'hFFFF_FFFF_FFFF, 48'h02_00_00_00_00_AA, ETH_TYPE_ARP, 28, 1'b0);
      expect_frame();
      fork
         send_frame(0);
         begin
            for (int k = 0; k < 200 && !hif.valid; k++) @(negedge clk);
            check("stall_hdr_valid_seen", 64'(hif.valid), 64'd1);
            repeat (20) begin
               check("stall_s_tready", 64'(s_axis_tready), 64'd0);
               @(negedge clk);
            end
            hold_hdr = 1'b0;
         end
      join
      idle(5);

      // 64-byte IPv4 frame under random downstream backpressure.
      rand_m = 1'b1;
      make_frame(LOCAL, 48'h02_11_22_33_44_55, ETH_TYPE_IPV4, 50, 1'b1);
      expect_frame();
      send_frame(0);
      idle(5);
      rand_m = 1'b0;

      // 10-byte runt followed by a good frame.
      make_frame(48'h02_00_00_00_00_01, 48'h02_00_00_00_00_BB, ETH_TYPE_IPV4, 0, 1'b0);
      repeat (4) void'(cur_fr.pop_back());
      expect_frame();
      send_frame(0);
      make_frame(LOCAL, 48'h02_00_00_00_00_CC, ETH_TYPE_IPV4, 6, 1'b1);
      expect_frame();
      send_frame(0);
      idle(5);
      check("runt_count_after_runt", 64'(runt_seen), 64'(runt_exp));

      // Back-to-back frames with tvalid never dropping between them.
      make_frame(48'hFFFF_FFFF_FFFF, 48'h02_00_00_00_00_01, ETH_TYPE_ARP, 3, 1'b1);
      expect_frame();
      send_frame(0);
      make_frame(LOCAL, 48'h02_00_00_00_00_02, ETH_TYPE_IPV4, 5, 1'b1);
      expect_frame();
      send_frame(0);
      idle(5);

      // Foreign unicast then local: dropped only when filtering is built in.
      make_frame(48'h02_00_00_00_00_02, 48'h02_00_00_00_00_DD, ETH_TYPE_IPV4, 8, 1'b1);
      expect_frame();
      send_frame(0);
      make_frame(LOCAL, 48'h02_00_00_00_00_DD, ETH_TYPE_IPV4, 8, 1'b1);
      expect_frame();
      send_frame(0);
      idle(5);

      // Randomised frames, lengths spanning the runt boundary, random gaps and backpressure.
      rand_m = 1'b1;
      rand_h = 1'b1;
      for (int f = 0; f < 16; f++) begin
         case ($urandom_range(2))
            0:       d = LOCAL;
            1:       d = 48'hFFFF_FFFF_FFFF;
            default: d = {$urandom, 16'($urandom)};
         endcase
         make_frame(d, {$urandom, 16'($urandom)}, 16'($urandom), int'($urandom_range(20)), 1'b1);
         if ($urandom_range(3) == 0) begin
            while (cur_fr.size() > 1 + int'($urandom_range(13))) void'(cur_fr.pop_back());
         end
         expect_frame();
         send_frame(20);
         if ($urandom_range(1) == 1) idle(int'($urandom_range(3)));
      end
      idle(60);
      rand_m = 1'b0;
      rand_h = 1'b0;

      check("hdr_queue_drained", 64'(hdr_q.size()), 64'd0);
      check("payload_queue_drained", 64'(pay_q.size()), 64'd0);
      check("runt_count_final", 64'(runt_seen), 64'(runt_exp));
      check("final_hdr_valid_idle", 64'(hif.valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
